c499_key_loader: RTL



---
 rtl/c499_key_pkg.sv | 35 +++
 rtl/c499_key_shreg.sv | 39 +++
 rtl/c499_key_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/c499_key_pkg.sv
// Shared constants, state encoding and key bit-mapping for the c499 key loader.
package c499_key_pkg;

   localparam int KEY_W   = 24;
   localparam int P_W     = 4;
   localparam int X_W     = 20;
   localparam int ERR_MAX = 3;

   localparam int CNT_W   = $clog2(KEY_W + 1);
   localparam int ERR_W   = $clog2(ERR_MAX + 1);

   // Position of the mux-select and XOR fields inside the 24-bit shadow.
   // Shadow bit 23 is p1, bit 20 is p4, bit 19 is X_1, bit 0 is X_20.
   localparam int P_MSB   = KEY_W - 1;
   localparam int P_LSB   = KEY_W - P_W;
   localparam int X_MSB   = X_W - 1;
   localparam int X_LSB   = 0;

   typedef enum logic [2:0] {
      LOAD,
      PAR,
      COMMIT,
      ERR,
      LOCKOUT
   } state_t;

   function automatic logic [P_W-1:0] key_p_field(input logic [KEY_W-1:0] k);
      return k[P_MSB:P_LSB];
   endfunction

   function automatic logic [X_W-1:0] key_x_field(input logic [KEY_W-1:0] k);
      return k[X_MSB:X_LSB];
   endfunction

endpackage

// File: rtl/c499_key_shreg.sv
// 24-bit key shadow shift register with beat counter and running parity.
// The first shifted bit ends up in the MSB once the frame is complete.
module c499_key_shreg
   import c499_key_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift,
   input  logic             bit_in,
   output logic [KEY_W-1:0] data,
   output logic             last,
   output logic             full,
   output logic             par_ok
);

   logic [CNT_W-1:0] cnt;
   logic             par_acc;

   // Shift data beats in, count them and accumulate their parity.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         data    <= '0;
         cnt     <= '0;
         par_acc <= 1'b0;
      end else if (shift && !full) begin
         data    <= {data[KEY_W-2:0], bit_in};
         cnt     <= cnt + CNT_W'(1);
         par_acc <= par_acc ^ bit_in;
      end
   end

   assign last   = (cnt == CNT_W'(KEY_W - 1));
   assign full   = (cnt == CNT_W'(KEY_W));
   // The presented bit is the parity beat when this is consulted.
   assign par_ok = ~(par_acc ^ bit_in);

endmodule

// File: rtl/c499_key_loader.sv
// Serial key loader / commit controller for the locked c499 corrector.
// Collects a 24-bit frame plus parity beat, commits it atomically on good
// parity and locks out after ERR_MAX consecutive parity failures.
module c499_key_loader
   import c499_key_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           clear,
   input  logic           key_bit,
   input  logic           key_valid,
   output logic           key_ready,
   output logic [P_W-1:0] p_key,
   output logic [X_W-1:0] x_key,
   output logic           key_ok,
   output logic           par_err,
   output logic           lockout
);

   state_t           state, state_nx;
   logic [ERR_W-1:0] err_cnt;
   logic [KEY_W-1:0] shadow;
   logic             sh_last, sh_full, sh_par_ok;
   logic             sh_shift, sh_clr;
   logic             commit_en, err_en, zero_key;

   c499_key_shreg u_shreg (
      .clk    (clk),
      .rst    (rst),
      .clr    (sh_clr),
      .shift  (sh_shift),
      .bit_in (key_bit),
      .data   (shadow),
      .last   (sh_last),
      .full   (sh_full),
      .par_ok (sh_par_ok)
   );

   // Next-state, handshake and datapath-control decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nx  = state;
      key_ready = 1'b0;
      sh_shift  = 1'b0;
      sh_clr    = 1'b0;
      commit_en = 1'b0;
      err_en    = 1'b0;
      zero_key  = 1'b0;

      if (state == LOCKOUT) begin
         // Only rst leaves lockout; clear merely zeroizes the committed key.
         zero_key = clear;
      end else if (clear) begin
         zero_key = 1'b1;
         sh_clr   = 1'b1;
         state_nx = LOAD;
      end else begin
         case (state)
            LOAD: begin
               key_ready = 1'b1;
               if (key_valid) begin
                  sh_shift = 1'b1;
                  if (sh_last) state_nx = PAR;
               end
            end
            PAR: begin
               key_ready = 1'b1;
               if (key_valid && sh_full) state_nx = sh_par_ok ? COMMIT : ERR;
            end
            COMMIT: begin
               commit_en = 1'b1;
               sh_clr    = 1'b1;
               state_nx  = LOAD;
            end
            ERR: begin
               err_en   = 1'b1;
               sh_clr   = 1'b1;
               state_nx = (err_cnt == ERR_W'(ERR_MAX - 1)) ? LOCKOUT : LOAD;
            end
            default: state_nx = LOAD;
         endcase
      end

      if (rst) key_ready = 1'b0;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= state_nx;
   end

   // Consecutive parity-failure counter; a good commit restarts it.
   always_ff @(posedge clk) begin
      if (rst)            err_cnt <= '0;
      else if (commit_en) err_cnt <= '0;
      else if (err_en)    err_cnt <= err_cnt + ERR_W'(1);
   end

   // Committed key registers driving the corrector's p/X inputs.
   always_ff @(posedge clk) begin
      if (rst || zero_key) begin
         p_key  <= '0;
         x_key  <= '0;
         key_ok <= 1'b0;
      end else if (commit_en) begin
         p_key  <= key_p_field(shadow);
         x_key  <= key_x_field(shadow);
         key_ok <= 1'b1;
      end
   end

   // Registered status flags, aligned with the ERR and LOCKOUT states.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_err <= 1'b0;
         lockout <= 1'b0;
      end else begin
         par_err <= (state_nx == ERR);
         lockout <= (state_nx == LOCKOUT);
      end
   end

endmodule
